bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter. It is the inverse of the existing binary-to-BCD digit decoder that feeds the 7-segment path. It accepts three BCD digits (hundreds/tens/units) over a valid/ready handshake and accumulates them MSD-first, one digit per cycle, using acc = acc*10 + digit. It returns a 10-bit binary value plus an error flag for non-BCD digits. It sits between keypad/display digit registers and the arithmetic datapath.

Parameters:
- NDIG, 3, number of BCD digits converted per transaction.
- BIN_W, 10, binary result width. Must satisfy 2^BIN_W > 10^NDIG - 1; elaboration fails otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  digit triple present.
- in_ready  output  1  block can accept a triple.
- numb3  input  4  hundreds digit (BCD).
- numb2  input  4  tens digit (BCD).
- numb1  input  4  units digit (BCD).
- out_valid  output  1  result held on bin/err.
- out_ready  input  1  consumer takes result.
- bin  output  BIN_W  binary result.
- err  output  1  at least one input digit > 9.

Behaviour:
- Reset: one clock, one synchronous active-low reset (rst_n), no async path. When rst_n=0 at an edge:
  - state=IDLE
  - bin=0, err=0, out_valid=0
  - in_ready=1 from the cycle after reset.
  - Reset mid-conversion abandons the transaction silently; no out_valid pulse.
- FSM states: IDLE, CONV, DONE. Outputs are registered or decoded from state only, with no combinational in->out paths.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch {numb3,numb2,numb1} into a digit register, acc=0, idx=NDIG-1, err_int=0, then go to CONV.
- CONV:
  - in_ready=0, out_valid=0.
  - Each edge: acc <= trunc_BIN_W(acc*10 + digit[idx]). The intermediate is computed in BIN_W+4 bits.
  - If digit[idx] > 9, set err_int (sticky).
  - Decrement idx. After the edge that processes idx=0, go to DONE.
  - Exactly NDIG CONV cycles.
- DONE:
  - out_valid=1. bin=acc, or 0 if err_int=1 (safe-zero output). err=err_int.
  - bin and err are stable while out_valid=1 && out_ready=0. Back-pressure is unbounded.
  - On an edge with out_ready=1: go to IDLE; out_valid drops next cycle. bin/err keep their last value.
- Latency: with accept at edge E0, out_valid is high after edge E0+NDIG (E0+3 by default).
- Throughput: minimum 5 cycles per transaction at NDIG=3, because in_ready=0 in DONE and there is no same-edge re-accept.
- Inputs numb* are ignored outside the accepting edge. Changes during CONV have no effect.
- in_valid held high across DONE->IDLE is accepted at the first IDLE edge.
- Boundary values:
  - 000 -> 0.
  - 999 -> 999 with no overflow at default parameters.
  - Any digit in 10..15 -> err=1, bin=0, regardless of position.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4, MAX_DIGIT=4'd9.
  - Default NDIG/BIN_W constants.
  - Typedef state_t enum {IDLE, CONV, DONE}.
  - Typedef digit_t logic[3:0].
- Sub-module mul10_add (combinational): computes (acc<<3)+(acc<<1)+digit and a digit-invalid flag. It is instantiated once, and the FSM wraps around it.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> bin=0, err=0, out_valid=0; in_ready=1 after release.
- Conversion with stall: digits 3,4,5 with out_ready=0 -> out_valid rises 3 edges after accept; bin=345, err=0, held 10 cycles; then out_ready=1 -> out_valid=0 next cycle.
- Extremes: 0,0,0 -> bin=0. 9,9,9 -> bin=999. 1,0,0 -> bin=100. 0,0,7 -> bin=7. All with err=0.
- Invalid digits: 2,12,5 -> err=1, bin=0. 15,0,0 -> err=1, bin=0. A following valid 1,2,3 -> err=0, bin=123 (err not sticky across transactions).
- Mid-conversion disturbance:
  - Change numb* during CONV -> result reflects latched values.
  - Assert rst_n=0 in the 2nd CONV cycle -> no out_valid; outputs 0; next transaction 8,0,1 -> 801.
- Back-to-back: in_valid held high with out_ready=1 over 4 transactions -> each accept spaced exactly 5 cycles apart; results match the golden model (hundreds*100 + tens*10 + units).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential BCD-to-binary converter.
package bcd_pkg;

  localparam int DIGIT_W   = 4;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  localparam int DEF_NDIG  = 3;
  localparam int DEF_BIN_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] digit_t;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/mul10_add.sv
// One accumulation step: acc*10 + digit, built as shift-add, plus a non-BCD digit flag.
// Purely combinational.
module mul10_add
  import bcd_pkg::*;
#(
  parameter int BIN_W = DEF_BIN_W
) (
  input  logic [BIN_W-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [BIN_W-1:0] acc_o,
  output logic             ovf_o,
  output logic             bad_o
);

  logic [BIN_W+3:0] acc_w;
  logic [BIN_W+3:0] wide;

  assign acc_w = {4'b0000, acc_i};
  assign wide  = (acc_w << 3) + (acc_w << 1) + {{BIN_W{1'b0}}, digit_i};
  assign acc_o = wide[BIN_W-1:0];
  assign ovf_o = |wide[BIN_W+3:BIN_W];
  assign bad_o = (digit_i > MAX_DIGIT);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Converts a hundreds/tens/units BCD triple to binary, MSD first, one digit per cycle.
// Result valid NDIG edges after accept; held indefinitely under out_ready back-pressure.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG  = DEF_NDIG,
  parameter int BIN_W = DEF_BIN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       numb3,
  input  logic [3:0]       numb2,
  input  logic [3:0]       numb1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] bin,
  output logic             err
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DIG_W = NDIG * DIGIT_W;

  // Largest NDIG-digit decimal value must fit in BIN_W bits.
  if (((pow10(NDIG) - 1) >> BIN_W) != 0) begin : g_width_chk
    $error("BIN_W too narrow for NDIG decimal digits");
  end

  state_t             state_q;
  logic [DIG_W-1:0]   dig_q;
  logic [BIN_W-1:0]   acc_q;
  logic [IDX_W-1:0]   idx_q;
  logic               err_int_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [BIN_W-1:0]   bin_q;
  logic               err_q;

  digit_t             cur_digit;
  logic [BIN_W-1:0]   acc_d;
  logic               ovf;
  logic               bad;
  logic               err_d;

  assign cur_digit = dig_q[idx_q*DIGIT_W +: DIGIT_W];
  assign err_d     = err_int_q | bad;

  mul10_add #(.BIN_W(BIN_W)) u_mul10_add (
    .acc_i   (acc_q),
    .digit_i (cur_digit),
    .acc_o   (acc_d),
    .ovf_o   (ovf),
    .bad_o   (bad)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dig_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      err_int_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dig_q      <= DIG_W'({numb3, numb2, numb1});
            acc_q      <= '0;
            idx_q      <= IDX_W'(NDIG - 1);
            err_int_q  <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= CONV;
          end
        end
        CONV: begin
          acc_q     <= acc_d;
          err_int_q <= err_d;
          if (idx_q == '0) begin
            // Any bad digit forces a zero result so downstream never sees garbage.
            bin_q       <= err_d ? '0 : acc_d;
            err_q       <= err_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin       = bin_q;
  assign err       = err_q;

  ovf_never: assert property (@(posedge clk) disable iff (!rst_n)
                              !((state_q == CONV) && !bad && !err_int_q && ovf));

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: vector table, corner sequences, random traffic.
module tb_bcd_to_bin_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] numb3, numb2, numb1;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] bin;
  logic       err;

  int nvec = 0;
  int nmis = 0;

  bcd_to_bin_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .numb3     (numb3),
    .numb2     (numb2),
    .numb1     (numb1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    int         stall;
  } vec_t;

  vec_t tbl[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: decimal value of the three digits, or zero with error if any digit is not BCD.
  function automatic void ref_conv(input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] c, output int eb, output int ee);
    ee = (a > 9 || b > 9 || c > 9) ? 1 : 0;
    eb = (ee != 0) ? 0 : int'(a) * 100 + int'(b) * 10 + int'(c);
  endfunction

  task automatic do_txn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input int stall, input string nm);
    int eb, ee, n;
    ref_conv(a, b, c, eb, ee);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk({nm, "_rdy"}, int'(in_ready), 1);
    in_valid = 1'b1;
    numb3 = a; numb2 = b; numb1 = c;
    tick();
    in_valid = 1'b0;
    numb3 = 4'($urandom); numb2 = 4'($urandom); numb1 = 4'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk({nm, "_lat"}, n, 3);
    chk({nm, "_bin"}, int'(bin), eb);
    chk({nm, "_err"}, int'(err), ee);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({nm, "_hold_vld"}, int'(out_valid), 1);
      chk({nm, "_hold_bin"}, int'(bin), eb);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_drop"}, int'(out_valid), 0);
    chk({nm, "_keep"}, int'(bin), eb);
  endtask

  initial begin
    int n_ov, cyc, nacc, nres, eb, ee;
    logic accept_now;
    logic [3:0] ra, rb, rc;
    int acc_cyc[$];
    int exp_bin[$];
    int exp_err[$];

    tbl[0]  = '{4'd0, 4'd0,  4'd0, 0};
    tbl[1]  = '{4'd9, 4'd9,  4'd9, 1};
    tbl[2]  = '{4'd1, 4'd0,  4'd0, 0};
    tbl[3]  = '{4'd0, 4'd0,  4'd7, 2};
    tbl[4]  = '{4'd3, 4'd4,  4'd5, 10};
    tbl[5]  = '{4'd2, 4'd12, 4'd5, 0};
    tbl[6]  = '{4'd15, 4'd0, 4'd0, 1};
    tbl[7]  = '{4'd0, 4'd0,  4'd10, 0};
    tbl[8]  = '{4'd1, 4'd2,  4'd3, 0};
    tbl[9]  = '{4'd8, 4'd0,  4'd1, 0};
    tbl[10] = '{4'd5, 4'd6,  4'd7, 3};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    numb3 = 4'd0; numb2 = 4'd0; numb1 = 4'd0;
    tick(); tick();
    chk("rst_bin", int'(bin), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ovld", int'(out_valid), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_inrdy", int'(in_ready), 1);

    for (int i = 0; i < 11; i++)
      do_txn(tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].stall, $sformatf("tbl%0d", i));

    // Reset in the second conversion cycle must abandon the transaction.
    in_valid = 1'b1;
    numb3 = 4'd3; numb2 = 4'd4; numb1 = 4'd5;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_ovld", int'(out_valid), 0);
    chk("midrst_bin", int'(bin), 0);
    chk("midrst_err", int'(err), 0);
    n_ov = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) n_ov++;
    end
    chk("midrst_no_ovld", n_ov, 0);
    do_txn(4'd8, 4'd0, 4'd1, 0, "after_rst");

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    numb3 = 4'($urandom_range(0, 9));
    numb2 = 4'($urandom_range(0, 11));
    numb1 = 4'($urandom_range(0, 9));
    cyc = 0; nacc = 0; nres = 0;
    while (nres < 4 && cyc < 100) begin
      if (out_valid) begin
        if (exp_bin.size() > 0) begin
          chk("b2b_bin", int'(bin), exp_bin.pop_front());
          chk("b2b_err", int'(err), exp_err.pop_front());
        end else begin
          chk("b2b_unexpected", 1, 0);
        end
        nres++;
      end
      accept_now = in_valid && in_ready;
      if (accept_now) begin
        acc_cyc.push_back(cyc);
        ref_conv(numb3, numb2, numb1, eb, ee);
        exp_bin.push_back(eb);
        exp_err.push_back(ee);
        nacc++;
      end
      tick();
      cyc++;
      if (accept_now) begin
        if (nacc < 4) begin
          numb3 = 4'($urandom_range(0, 9));
          numb2 = 4'($urandom_range(0, 11));
          numb1 = 4'($urandom_range(0, 9));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_results", nres, 4);
    chk("b2b_accepts", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 5);
    tick();

    for (int i = 0; i < 25; i++) begin
      ra = 4'($urandom_range(0, 11));
      rb = 4'($urandom_range(0, 9));
      rc = 4'($urandom_range(0, 11));
      do_txn(ra, rb, rc, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
